// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: compacts valid fetch slots into a circular
// queue and presents the two oldest in order. Define IBUF_BYPASS_EN for the same-cycle empty bypass.
module inst_buffer #(
  parameter int PIPE_WIDTH    = 2,
  parameter int DEPTH         = 8,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_INST_BITS = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  output logic                                     fetch_rdy,
  input  logic                                     fetch_val,
  input  logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] fetch_pcs,
  input  logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] fetch_insts,
  input  logic [PIPE_WIDTH-1:0]                    fetch_slot_val,
  input  logic                                     decode_rdy,
  output logic                                     inst_val,
  output logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] inst_pcs,
  output logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] insts
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] pc;
    logic [CPU_INST_BITS-1:0] inst;
  } entry_t;

  entry_t     mem [DEPTH];
  ptr_t       head;
  ptr_t       tail;
  cnt_t       count;

  ptr_t       head_p1;
  ptr_t       tail_p1;
  entry_t     cmp0;
  entry_t     cmp1;
  logic [1:0] in_n;
  logic       enq_fire;
  logic       deq_fire;
  logic       byp_active;
  logic       byp_take;
  logic [1:0] enq_n;
  logic [1:0] deq_n;
  cnt_t       count_next;

  assign head_p1 = head + ptr_t'(1);
  assign tail_p1 = tail + ptr_t'(1);

  // Room for a whole group is judged from registered state only, so a full
  // buffer never relies on a same-cycle dequeue to avoid overflow.
  assign fetch_rdy = rst && (count <= cnt_t'(DEPTH - 2));
  assign enq_fire  = fetch_val && fetch_rdy && !flush;
  assign in_n      = {1'b0, fetch_slot_val[0]} + {1'b0, fetch_slot_val[1]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cmp0 = '0;
    cmp1 = '0;
    case (fetch_slot_val)
      2'b01: cmp0 = '{pc: fetch_pcs[0], inst: fetch_insts[0]};
      2'b10: cmp0 = '{pc: fetch_pcs[1], inst: fetch_insts[1]};
      2'b11: begin
        cmp0 = '{pc: fetch_pcs[0], inst: fetch_insts[0]};
        cmp1 = '{pc: fetch_pcs[1], inst: fetch_insts[1]};
      end
      default: ;
    endcase
  end

`ifdef IBUF_BYPASS_EN
  assign byp_active = enq_fire && (count == '0) && (in_n != 2'd0);
`else
  assign byp_active = 1'b0;
`endif
  assign byp_take = byp_active && decode_rdy;

  always_comb begin
    inst_val = 1'b0;
    inst_pcs = '0;
    insts    = '0;
    if (byp_active) begin
      inst_val    = 1'b1;
      inst_pcs[0] = cmp0.pc;
      insts[0]    = cmp0.inst;
      inst_pcs[1] = cmp1.pc;
      insts[1]    = cmp1.inst;
    end else if (count != '0) begin
      inst_val    = 1'b1;
      inst_pcs[0] = mem[head].pc;
      insts[0]    = mem[head].inst;
      // A lone oldest entry is paired with an all-zero slot that decode treats as a bubble.
      if (count >= cnt_t'(2)) begin
        inst_pcs[1] = mem[head_p1].pc;
        insts[1]    = mem[head_p1].inst;
      end
    end
  end

  assign deq_fire = inst_val && decode_rdy && !flush;

  always_comb begin
    enq_n = 2'd0;
    deq_n = 2'd0;
    if (enq_fire && !byp_take) enq_n = in_n;
    if (deq_fire && !byp_take) deq_n = (count >= cnt_t'(2)) ? 2'd2 : 2'd1;
  end

  assign count_next = count + cnt_t'(enq_n) - cnt_t'(deq_n);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(deq_n);
      tail  <= tail + ptr_t'(enq_n);
      count <= count_next;
    end
  end

  // NOTE: entry storage is deliberately not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) mem[tail] <= cmp0;
    if (enq_n == 2'd2) mem[tail_p1] <= cmp1;
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH=8); the bypass scenario
// replaces the basic pass-through scenario when IBUF_BYPASS_EN is defined.
module tb_inst_buffer;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             fetch_rdy;
  logic             fetch_val;
  logic [1:0][31:0] fetch_pcs;
  logic [1:0][31:0] fetch_insts;
  logic [1:0]       fetch_slot_val;
  logic             decode_rdy;
  logic             inst_val;
  logic [1:0][31:0] inst_pcs;
  logic [1:0][31:0] insts;

  int checks   = 0;
  int failures = 0;

  inst_buffer #(
    .PIPE_WIDTH(2), .DEPTH(8), .CPU_ADDR_BITS(32), .CPU_INST_BITS(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_rdy(fetch_rdy),
    .fetch_val(fetch_val), .fetch_pcs(fetch_pcs), .fetch_insts(fetch_insts),
    .fetch_slot_val(fetch_slot_val), .decode_rdy(decode_rdy),
    .inst_val(inst_val), .inst_pcs(inst_pcs), .insts(insts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic drive(input logic v, input logic [1:0] sv, input logic [31:0] pc0, input logic [31:0] pc1);
    fetch_val      = v;
    fetch_slot_val = sv;
    fetch_pcs      = {pc1, pc0};
    fetch_insts    = {ins(pc1), ins(pc0)};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] nxt_grp;
  logic        accept;

  initial begin
    rst = 1'b0; flush = 1'b0; decode_rdy = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_fetch_rdy", fetch_rdy, 0);
      check("rst_inst_val", inst_val, 0);
      check("rst_insts", insts, 0);
    end
    rst = 1'b1;
    tick();
    check("rel_fetch_rdy", fetch_rdy, 1);
    check("rel_inst_val", inst_val, 0);
    check("rel_inst_pcs", inst_pcs, 0);

`ifdef IBUF_BYPASS_EN
    // Empty buffer: group appears the same cycle and is consumed without being stored
    decode_rdy = 1'b1;
    drive(1'b1, 2'b11, 32'h300, 32'h304);
    #1;
    check("byp_val", inst_val, 1);
    check("byp_pcs", inst_pcs, {32'h304, 32'h300});
    check("byp_insts", insts, {ins(32'h304), ins(32'h300)});
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    check("byp_empty_after", inst_val, 0);
    tick();
`else
    // Full group with decode ready: one cycle latency, then drained
    decode_rdy = 1'b1;
    drive(1'b1, 2'b11, 32'h100, 32'h104);
    tick();
    check("basic_val", inst_val, 1);
    check("basic_pcs", inst_pcs, {32'h104, 32'h100});
    check("basic_insts", insts, {ins(32'h104), ins(32'h100)});
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    check("basic_drained", inst_val, 0);
`endif

    // A fire with no valid slots changes nothing
    decode_rdy = 1'b0;
    drive(1'b1, 2'b00, 32'h180, 32'h184);
    tick();
    check("noslot_val", inst_val, 0);
    check("noslot_rdy", fetch_rdy, 1);

    // Compaction: only slot 1 valid lands in entry slot 0
    drive(1'b1, 2'b10, 32'hDEAD, 32'h204);
    tick();
    check("cmp_val", inst_val, 1);
    check("cmp_pc0", inst_pcs[0], 32'h204);
    check("cmp_inst0", insts[0], ins(32'h204));
    check("cmp_bubble_pc", inst_pcs[1], 0);
    check("cmp_bubble_inst", insts[1], 0);
    drive(1'b1, 2'b11, 32'h208, 32'h20C);
    tick();
    check("cmp_hold", inst_pcs, {32'h208, 32'h204});
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    decode_rdy = 1'b1;
    tick();
    check("cmp_tail_pcs", inst_pcs, {32'h0, 32'h20C});
    check("cmp_tail_inst1", insts[1], 0);
    tick();
    check("cmp_drained", inst_val, 0);

    // Fill to DEPTH with decode stalled
    decode_rdy = 1'b0;
    for (int g = 0; g < 4; g++) begin
      check("fill_rdy", fetch_rdy, 1);
      drive(1'b1, 2'b11, 32'h400 + 32'(8 * g), 32'h404 + 32'(8 * g));
      tick();
    end
    check("full_rdy", fetch_rdy, 0);
    check("full_head", inst_pcs, {32'h404, 32'h400});
    drive(1'b1, 2'b11, 32'hBAD0, 32'hBAD4);
    tick();
    check("full_drop_rdy", fetch_rdy, 0);
    check("full_drop_head", inst_pcs, {32'h404, 32'h400});

    // Drain with concurrent enqueue; pointers wrap past entry 7
    exp_pc  = 32'h400;
    nxt_grp = 32'h420;
    decode_rdy = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_pc != 32'h438; cyc++) begin
      check("wrap_val", inst_val, 1);
      check("wrap_pcs", inst_pcs, {exp_pc + 32'h4, exp_pc});
      check("wrap_inst0", insts[0], ins(exp_pc));
      if (nxt_grp < 32'h438) drive(1'b1, 2'b11, nxt_grp, nxt_grp + 32'h4);
      else drive(1'b0, 2'b00, 32'h0, 32'h0);
      accept = fetch_rdy && fetch_val;
      tick();
      exp_pc = exp_pc + 32'h8;
      if (accept) nxt_grp = nxt_grp + 32'h8;
    end
    check("wrap_done", exp_pc, 32'h438);
    check("wrap_empty", inst_val, 0);

    // Flush with five entries buffered and a group arriving
    decode_rdy = 1'b0;
    drive(1'b1, 2'b11, 32'h500, 32'h504); tick();
    drive(1'b1, 2'b11, 32'h508, 32'h50C); tick();
    drive(1'b1, 2'b01, 32'h510, 32'hDEAD); tick();
    check("pre_flush_head", inst_pcs, {32'h504, 32'h500});
    flush = 1'b1;
    drive(1'b1, 2'b11, 32'h600, 32'h604);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("flush_val", inst_val, 0);
    check("flush_rdy", fetch_rdy, 1);
    check("flush_pcs", inst_pcs, 0);
    tick();
    check("flush_dropped", inst_val, 0);
    drive(1'b1, 2'b01, 32'h700, 32'h0);
    tick();
    check("post_flush_pcs", inst_pcs, {32'h0, 32'h700});

    // Mid-operation reset discards buffered entries
    drive(1'b1, 2'b11, 32'h800, 32'h804);
    rst = 1'b0;
    #1;
    check("midrst_rdy_low", fetch_rdy, 0);
    tick();
    check("midrst_val", inst_val, 0);
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    check("midrst_empty", inst_val, 0);
    check("midrst_rdy", fetch_rdy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Instruction buffer between the fetch unit and the decode stage. It captures up to `PIPE_WIDTH` instructions per cycle from fetch, compacts away invalid fetch slots, and presents the oldest two instructions in program order to decode with a single valid/ready handshake. It decouples fetch bubbles and I-cache timing from decode/rename backpressure, and it drains completely on a pipeline flush.

## Interface
- `PIPE_WIDTH`, 2: instructions per fetch/decode group; the design is fixed at 2.
- `DEPTH`, 8: buffer capacity in instructions; power of two, ≥4.
- `CPU_ADDR_BITS`, 32: PC width.
- `CPU_INST_BITS`, 32: instruction width.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `flush`  in  1  synchronous pipeline flush; discards all buffered and incoming instructions.
- `fetch_rdy`  out  1  buffer can accept a full fetch group this cycle.
- `fetch_val`  in  1  fetch group valid.
- `fetch_pcs`  in  `CPU_ADDR_BITS` x `PIPE_WIDTH`  PC of each slot.
- `fetch_insts`  in  `CPU_INST_BITS` x `PIPE_WIDTH`  raw instruction per slot.
- `fetch_slot_val`  in  `PIPE_WIDTH`  per-slot valid. Slot 0 is invalid when a branch target is the second word. Slot 1 is invalid after a predicted-taken slot 0.
- `decode_rdy`  in  1  decode accepts the presented group.
- `inst_val`  out  1  group valid to decode; connects to decode `fetch_val`.
- `inst_pcs`  out  `CPU_ADDR_BITS` x `PIPE_WIDTH`  PCs to decode.
- `insts`  out  `CPU_INST_BITS` x `PIPE_WIDTH`  instructions to decode.

## Operation
- Storage is a circular array of `DEPTH` entries, each holding {pc, inst}.
- State is `head` and `tail` pointers of `$clog2(DEPTH)` bits, which wrap modulo `DEPTH`, plus `count` of `$clog2(DEPTH+1)` bits.
- `fetch_rdy` = rst high && (`DEPTH` − `count`) ≥ 2.
  - It depends only on registered state, never on a same-cycle dequeue.
  - Overflow is therefore impossible.
- Enqueue fires when `fetch_val && fetch_rdy && !flush`.
  - Valid slots are written at `tail`, `tail+1` in slot order, with invalid slots skipped (compaction).
  - `tail` advances by popcount(`fetch_slot_val`), which is 0, 1 or 2.
  - A fire with both slot valids 0 is legal and has no effect.
- Presentation is combinational from `head`:
  - `inst_val` = (`count` ≥ 1).
  - Slot 0 = entry[`head`].
  - Slot 1 = entry[`head+1`] if `count` ≥ 2. Otherwise slot 1 is pc 0 and inst 32'h0000_0000; opcode 0 is rejected by decode as invalid, so the slot becomes a bubble.
  - When `count` = 0, all outputs are 0.
- Dequeue fires when `inst_val && decode_rdy && !flush`. `head` advances by min(`count`, 2).
- `count`_next = `count` + enq_n − deq_n. Simultaneous enqueue and dequeue are allowed in every state, including full and one-entry.
- Flush: `head`, `tail` and `count` are set to 0.
  - Flush has priority over enqueue and dequeue in the same cycle; incoming fetch data in that cycle is dropped.
- Reset (`rst` low): same effect as flush. This applies mid-operation as well; buffered entries are lost. Entry data is not reset.

## Timing
- Reset values: `fetch_rdy` 0 while `rst` is low and 1 on the first cycle after release. `inst_val` 0, `inst_pcs` 0, `insts` 0.
- Latency: an instruction enqueued at edge N is presented to decode in cycle N+1 (one cycle, non-bypass build).
- Throughput: 2 instructions/cycle sustained when fetch delivers full groups and decode is ready.
- Outputs are held stable while `inst_val && !decode_rdy`, unless a flush occurs.
- After a flush edge: `inst_val` = 0 and `fetch_rdy` = 1 in the following cycle.

## Configuration
- `IBUF_BYPASS_EN` defined:
  - When `count` = 0 and enqueue fires, the compacted incoming group is presented combinationally the same cycle: `inst_val` = 1 if any slot is valid.
  - If `decode_rdy` is also high, the bypassed instructions are not written; otherwise they are written as normal.
  - Zero-cycle latency when empty.
  - Adds a `fetch_*` → `inst_*` combinational path.
- Not defined: there is no combinational path from `fetch_*` to `inst_*`, and the minimum latency is 1 cycle.

## Test plan
- Reset held 3 cycles, then released → `inst_val` = 0 and `insts` = 0 throughout; `fetch_rdy` = 0 during reset and 1 on the first cycle after release.
- Enqueue PCs 0x100/0x104 with both slots valid, `decode_rdy` = 1 → next cycle `inst_val` = 1, `inst_pcs` = {0x104, 0x100}; the following cycle `inst_val` = 0.
- Enqueue with `fetch_slot_val` = 2'b10 (PC 0x204) and `decode_rdy` = 0 → slot 0 = 0x204 and slot 1 inst = 0, `count` = 1. Then enqueue 0x208/0x20C → after `decode_rdy` = 1, groups {0x204, 0x208} then {0x20C, bubble}.
- Fill with `decode_rdy` = 0 for 4 full groups (`DEPTH` = 8) → `fetch_rdy` = 0 at `count` = 8. Then `decode_rdy` = 1 with concurrent enqueue → no loss, in-order PCs, and the pointers wrap past entry 7.
- `flush` asserted with `count` = 5 and `fetch_val` = 1 in the same cycle → next cycle `count` = 0 and `inst_val` = 0; the incoming group is dropped.
- `IBUF_BYPASS_EN` build, empty buffer, enqueue 0x300/0x304 with `decode_rdy` = 1 → same-cycle `inst_val` = 1, `inst_pcs` = {0x304, 0x300}, and `count` stays 0.
